// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and state encoding for the multicycle CPU
package cpu_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Cause code the main control unit selects through excpCtrl on a zero divisor
    localparam logic [1:0] EXCP_DIV_ZERO = 2'd2;

endpackage

// File: rtl/mult_div_core.sv
// rtl/mult_div_core.sv - shift-add multiply / restoring divide datapath with sign fix-up
module mult_div_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_mult,
    input  logic             load_div,
    input  logic             step_mult,
    input  logic             step_div,
    input  logic             fix,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // acc holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               neg_lo;
    logic               neg_hi;
    logic               is_div;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // One iteration's arithmetic: conditional add for MULT, trial subtract for DIV
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, opnd};
    end

    // Operand latch and iteration register; magnitudes only, signs are applied at FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            is_div <= 1'b0;
        end else if (load_mult) begin
            acc    <= {{WIDTH{1'b0}}, abs_b};
            opnd   <= abs_a;
            neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi <= a[WIDTH-1] ^ b[WIDTH-1];
            is_div <= 1'b0;
        end else if (load_div) begin
            acc    <= {{WIDTH{1'b0}}, abs_a};
            opnd   <= abs_b;
            neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi <= a[WIDTH-1];
            is_div <= 1'b1;
        end else if (step_mult) begin
            acc <= {add_sum, acc[WIDTH-1:1]};
        end else if (step_div) begin
            // A borrow out of the trial subtract means the divisor did not fit: restore
            if (!trial[WIDTH]) begin
                acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc <= {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    // HI/LO are written only at FIX so they hold across IDLE and divide-by-zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (fix) begin
            if (is_div) begin
                hi <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                lo <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end else begin
                {hi, lo} <= neg_lo ? -acc : acc;
            end
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - MULT/DIV control FSM, iteration counter and handshake outputs
module mult_div_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multControl,
    input  logic             divControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             last_step;
    logic             load_mult;
    logic             load_div;
    logic             step_mult;
    logic             step_div;
    logic             fix;
    logic             dz_start;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    // Next-state and datapath strobes; MULT has priority when both starts arrive
    always_comb begin
        next_state = state;
        load_mult  = 1'b0;
        load_div   = 1'b0;
        step_mult  = 1'b0;
        step_div   = 1'b0;
        fix        = 1'b0;
        dz_start   = 1'b0;
        case (state)
            IDLE: begin
                if (multControl) begin
                    load_mult  = 1'b1;
                    next_state = MULT;
                end else if (divControl) begin
                    if (b != '0) begin
                        load_div   = 1'b1;
                        next_state = DIV;
                    end else begin
                        dz_start   = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            MULT: begin
                step_mult = 1'b1;
                if (last_step) next_state = FIX;
            end
            DIV: begin
                step_div = 1'b1;
                if (last_step) next_state = FIX;
            end
            FIX: begin
                fix        = 1'b1;
                next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and iteration counter; counter runs only while stepping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= (step_mult || step_div) && !last_step ? cnt + 1'b1 : '0;
        end
    end

    // Handshake outputs registered from the next state so they line up with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            busy    <= (next_state == MULT) || (next_state == DIV) || (next_state == FIX);
            done    <= (next_state == DONE);
            divZero <= dz_start;
        end
    end

    mult_div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load_mult (load_mult),
        .load_div  (load_div),
        .step_mult (step_mult),
        .step_div  (step_div),
        .fix       (fix),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo)
    );

endmodule
